// File: rtl/data_memory_mmio_if.sv
// Load/store bus between the CPU datapath and data_memory_mmio.
// Single request per cycle, read data returns one cycle later.
interface data_memory_mmio_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 9
);
  logic                  req;
  logic                  read_write;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] data_in_memory;
  logic [DATA_WIDTH-1:0] data_out_memory;
  logic                  rvalid;

  modport master (
    output req,
    output read_write,
    output addr,
    output data_in_memory,
    input  data_out_memory,
    input  rvalid
  );

  modport slave (
    input  req,
    input  read_write,
    input  addr,
    input  data_in_memory,
    output data_out_memory,
    output rvalid
  );
endinterface

// File: rtl/data_memory_mmio.sv
// Data RAM with registered read plus LED, switch and
// switch-event registers shadowing three word addresses.
module data_memory_mmio #(
  parameter int DATA_WIDTH  = 16,
  parameter int ADDR_WIDTH  = 9,
  parameter int NUM_LED     = 4,
  parameter int NUM_SW      = 4,
  parameter int SYNC_STAGES = 2,
  parameter int LED_ADDR    = 0,
  parameter int SW_ADDR     = 4,
  parameter int EVT_ADDR    = 5
) (
  input  logic              clk,
  input  logic              reset,
  data_memory_mmio_if.slave bus,
  input  logic [NUM_SW-1:0] switch,
  output logic [NUM_LED-1:0] led
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  localparam logic [ADDR_WIDTH-1:0] LED_A =
    ADDR_WIDTH'(LED_ADDR);
  localparam logic [ADDR_WIDTH-1:0] SW_A =
    ADDR_WIDTH'(SW_ADDR);
  localparam logic [ADDR_WIDTH-1:0] EVT_A =
    ADDR_WIDTH'(EVT_ADDR);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [NUM_SW-1:0]  sync_q [SYNC_STAGES];
  logic [NUM_SW-1:0]  sw_sync;
  logic [NUM_SW-1:0]  prev_q;
  logic [NUM_SW-1:0]  evt_q;
  logic [NUM_SW-1:0]  sw_edge;
  logic [NUM_SW-1:0]  evt_clr;
  logic [NUM_LED-1:0] led_q;

  logic                  is_led;
  logic                  is_sw;
  logic                  is_evt;
  logic                  is_io;
  logic                  rd_en;
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] rd_mux;

  assign sw_sync = sync_q[SYNC_STAGES-1];
  assign sw_edge = sw_sync ^ prev_q;
  assign led     = led_q;

  assign is_led = (bus.addr == LED_A);
  assign is_sw  = (bus.addr == SW_A);
  assign is_evt = (bus.addr == EVT_A);
  assign is_io  = is_led | is_sw | is_evt;
  assign rd_en  = bus.req & ~bus.read_write;
  assign wr_en  = bus.req & bus.read_write;

  // Read source select: I/O registers shadow their RAM words
  always_comb begin
    rd_mux = '0;
    unique case (1'b1)
      is_led:  rd_mux = DATA_WIDTH'(led_q);
      is_sw:   rd_mux = DATA_WIDTH'(sw_sync);
      is_evt:  rd_mux = DATA_WIDTH'(evt_q);
      default: rd_mux = mem[bus.addr];
    endcase
  end

  // Event clear mask: read clears all, write clears the 1 bits
  always_comb begin
    evt_clr = '0;
    if (is_evt && rd_en)
      evt_clr = '1;
    else if (is_evt && wr_en)
      evt_clr = bus.data_in_memory[NUM_SW-1:0];
  end

  // RAM array write; contents survive reset
  always_ff @(posedge clk) begin
    if (!reset && wr_en && !is_io)
      mem[bus.addr] <= bus.data_in_memory;
  end

  // Switch synchroniser, edge history and sticky events
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++)
        sync_q[i] <= '0;
      prev_q <= '0;
      evt_q  <= '0;
    end else begin
      sync_q[0] <= switch;
      for (int i = 1; i < SYNC_STAGES; i++)
        sync_q[i] <= sync_q[i-1];
      prev_q <= sw_sync;
      evt_q  <= (evt_q & ~evt_clr) | sw_edge;
    end
  end

  // LED register and registered read port
  always_ff @(posedge clk) begin
    if (reset) begin
      led_q               <= '0;
      bus.rvalid          <= 1'b0;
      bus.data_out_memory <= '0;
    end else begin
      if (wr_en && is_led)
        led_q <= bus.data_in_memory[NUM_LED-1:0];
      bus.rvalid <= rd_en;
      if (rd_en)
        bus.data_out_memory <= rd_mux;
    end
  end

endmodule

// File: tb/tb_data_memory_mmio.sv
// Directed bench for data_memory_mmio: RAM, LED,
// switch sync, sticky events and reset behaviour.
module tb_data_memory_mmio;

  logic       clk;
  logic       reset;
  logic [3:0] switch;
  logic [3:0] led;

  int checks   = 0;
  int failures = 0;

  data_memory_mmio_if #(.DATA_WIDTH(16), .ADDR_WIDTH(9)) bus ();

  data_memory_mmio dut (
    .clk    (clk),
    .reset  (reset),
    .bus    (bus.slave),
    .switch (switch),
    .led    (led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [15:0] obs,
                     input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bus.req = 1'b0;
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic wr(input logic [8:0]  a,
                    input logic [15:0] d);
    bus.req            = 1'b1;
    bus.read_write     = 1'b1;
    bus.addr           = a;
    bus.data_in_memory = d;
    cyc();
    bus.req = 1'b0;
  endtask

  task automatic rd(input logic [8:0]  a,
                    input logic [15:0] exp,
                    input string       tag);
    bus.req        = 1'b1;
    bus.read_write = 1'b0;
    bus.addr       = a;
    cyc();
    bus.req = 1'b0;
    chk({tag, "_rv"}, 16'(bus.rvalid), 16'h1);
    chk(tag, bus.data_out_memory, exp);
  endtask

  initial begin
    reset              = 1'b1;
    switch             = 4'b0000;
    bus.req            = 1'b0;
    bus.read_write     = 1'b0;
    bus.addr           = '0;
    bus.data_in_memory = '0;
    cyc();
    cyc();
    reset = 1'b0;
    chk("rst_rv", 16'(bus.rvalid), 16'h0);
    chk("rst_do", bus.data_out_memory, 16'h0);
    chk("rst_led", 16'(led), 16'h0);

    wr(9'd10, 16'hBEEF);
    chk("wr_rv", 16'(bus.rvalid), 16'h0);
    rd(9'd10, 16'hBEEF, "ram10");
    idle(1);
    chk("idle_rv", 16'(bus.rvalid), 16'h0);
    chk("hold_do", bus.data_out_memory, 16'hBEEF);

    wr(9'd0, 16'h000A);
    chk("led_a", 16'(led), 16'h000A);
    rd(9'd0, 16'h000A, "rd_led_a");
    wr(9'd0, 16'hFFF5);
    chk("led_5", 16'(led), 16'h0005);
    rd(9'd0, 16'h0005, "rd_led_5");

    switch = 4'b0011;
    rd(9'd4, 16'h0000, "sw_e1");
    rd(9'd5, 16'h0000, "evt_e2");
    rd(9'd4, 16'h0003, "sw_e3");
    rd(9'd5, 16'h0003, "evt_e4");
    rd(9'd5, 16'h0000, "evt_clr");

    switch = 4'b0111;
    idle(2);
    rd(9'd5, 16'h0000, "evt_race");
    rd(9'd5, 16'h0004, "evt_sbc");
    rd(9'd5, 16'h0000, "evt_sbc_clr");

    switch = 4'b1010;
    idle(4);
    wr(9'd5, 16'h0004);
    wr(9'd5, 16'h0001);
    rd(9'd5, 16'h0008, "evt_w1c");
    rd(9'd5, 16'h0000, "evt_w1c_clr");

    wr(9'd4, 16'h1234);
    rd(9'd4, 16'h000A, "sw_ro");
    wr(9'd300, 16'h1234);
    rd(9'd300, 16'h1234, "ram300");
    rd(9'd300, 16'h1234, "b2b_0");
    rd(9'd10, 16'hBEEF, "b2b_1");
    rd(9'd300, 16'h1234, "b2b_2");
    idle(1);
    chk("b2b_end_rv", 16'(bus.rvalid), 16'h0);

    wr(9'd0, 16'h000F);
    chk("led_f", 16'(led), 16'h000F);
    switch = 4'b1111;
    idle(4);
    bus.req        = 1'b1;
    bus.read_write = 1'b0;
    bus.addr       = 9'd10;
    reset          = 1'b1;
    cyc();
    reset   = 1'b0;
    bus.req = 1'b0;
    chk("mid_rv", 16'(bus.rvalid), 16'h0);
    chk("mid_do", bus.data_out_memory, 16'h0);
    chk("mid_led", 16'(led), 16'h0);
    rd(9'd5, 16'h0000, "mid_evt");
    rd(9'd10, 16'hBEEF, "ram_keep");
    idle(1);
    rd(9'd5, 16'h000F, "evt_init");

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
